// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: groups the run-control, product-input and
// result-output handshakes of mac_accumulator. clk and rst are not part
// of this interface and stay plain ports on the block.
interface mac_accumulator_if #(
   parameter int PROD_W = 64,
   parameter int CNT_W  = 8
);
   logic              start;
   logic [CNT_W-1:0]  len;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] product;
   logic              product_ovf;
   logic              out_valid;
   logic              out_ready;
   logic [PROD_W-1:0] acc;
   logic              acc_ovf;
   logic              busy;

   // Producer/consumer side: starts runs, supplies products, takes results.
   modport master (
      output start, len, in_valid, product, product_ovf, out_ready,
      input  in_ready, out_valid, acc, acc_ovf, busy
   );

   // Accumulator side.
   modport slave (
      input  start, len, in_valid, product, product_ovf, out_ready,
      output in_ready, out_valid, acc, acc_ovf, busy
   );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a run of len signed products into acc, with a
// sticky overflow flag covering both multiplier overflow and add overflow.
// Optional feature: define MAC_ACC_SATURATE_EN to clamp acc on add
// overflow instead of wrapping modulo 2^PROD_W. acc_ovf is the same in
// both builds.
module mac_accumulator #(
   parameter int PROD_W = 64,
   parameter int CNT_W  = 8
) (
   input logic                 clk,
   input logic                 rst,
   mac_accumulator_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [PROD_W-1:0] ACC_MAX = {1'b0, {(PROD_W-1){1'b1}}};
   localparam logic [PROD_W-1:0] ACC_MIN = {1'b1, {(PROD_W-1){1'b0}}};

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PROD_W-1:0] acc_q,   acc_d;
   logic              acc_ovf_q, acc_ovf_d;

   logic [PROD_W-1:0] sum;
   logic              add_ovf;
   logic [PROD_W-1:0] acc_add;

   // Two's complement add; overflow when like-signed addends give a sum
   // of the opposite sign.
   assign sum     = acc_q + bus.product;
   assign add_ovf = (acc_q[PROD_W-1] == bus.product[PROD_W-1]) &&
                    (sum[PROD_W-1]   != acc_q[PROD_W-1]);

`ifdef MAC_ACC_SATURATE_EN
   // On overflow both addends share a sign, so acc's sign gives the clamp direction.
   assign acc_add = add_ovf ? (acc_q[PROD_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
   // Plain wrap-around modulo 2^PROD_W.
   assign acc_add = sum;
`endif

   // State, count and accumulator registers; reset discards any partial run.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         acc_q     <= '0;
         acc_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         acc_q     <= acc_d;
         acc_ovf_q <= acc_ovf_d;
      end
   end

   // Next-state logic: start a run, accumulate transfers, hold the result.
   // NOTE: every variable gets a hold-value default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      acc_ovf_d = acc_ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d     = '0;
               acc_ovf_d = 1'b0;
               count_d   = bus.len;
               state_d   = (bus.len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               acc_d     = acc_add;
               acc_ovf_d = acc_ovf_q | bus.product_ovf | add_ovf;
               count_d   = count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.acc       = acc_q;
   assign bus.acc_ovf   = acc_ovf_q;

endmodule
